// File: rtl/traffic_interval_timer.sv
// Interval timer for the intersection controller: a prescaled seconds counter
// compared against short/long lengths latched on each ST restart.
module traffic_interval_timer #(
   parameter int CLK_DIV   = 50000000,
   parameter int CNT_W     = 8,
   parameter int DEF_SHORT = 5,
   parameter int DEF_LONG  = 30
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             ST,
   input  logic [CNT_W-1:0] short_len,
   input  logic [CNT_W-1:0] long_len,
   output logic             TS,
   output logic             TL,
   output logic             tick,
   output logic [CNT_W-1:0] elapsed
);

   localparam int               PW        = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam logic [PW-1:0]    PRESC_MAX = PW'(CLK_DIV - 1);
   localparam logic [CNT_W-1:0] CNT_MAX   = '1;
   localparam logic [CNT_W-1:0] DEF_S     = CNT_W'(DEF_SHORT);
   localparam logic [CNT_W-1:0] DEF_L     = CNT_W'(DEF_LONG);

   logic [PW-1:0]    presc_q,   presc_d;
   logic [CNT_W-1:0] elapsed_q, elapsed_d;
   logic [CNT_W-1:0] short_q,   short_d;
   logic [CNT_W-1:0] long_q,    long_d;
   logic             tick_q,    tick_d;
   logic             tick_cond;

   always_comb begin
      presc_d   = presc_q;
      elapsed_d = elapsed_q;
      short_d   = short_q;
      long_d    = long_q;
      tick_cond = (presc_q == PRESC_MAX);
      if (ST) begin
         // Restart wins over a coincident tick; that tick is simply lost.
         presc_d   = '0;
         elapsed_d = '0;
         short_d   = short_len;
         long_d    = long_len;
      end else begin
         presc_d = tick_cond ? '0 : presc_q + 1'b1;
         if (tick_cond && (elapsed_q != CNT_MAX)) begin
            elapsed_d = elapsed_q + 1'b1;
         end
      end
      tick_d = (presc_d == PRESC_MAX);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         presc_q   <= '0;
         elapsed_q <= '0;
         short_q   <= DEF_S;
         long_q    <= DEF_L;
         tick_q    <= 1'b0;
      end else begin
         presc_q   <= presc_d;
         elapsed_q <= elapsed_d;
         short_q   <= short_d;
         long_q    <= long_d;
         tick_q    <= tick_d;
      end
   end

   // Outputs come from registers only: the controller builds ST from TS/TL.
   assign TS      = (elapsed_q >= short_q);
   assign TL      = (elapsed_q >= long_q);
   assign tick    = tick_q;
   assign elapsed = elapsed_q;

endmodule

// File: tb/tb_traffic_interval_timer.sv
// Directed bench for traffic_interval_timer with CLK_DIV=4, CNT_W=4,
// DEF_SHORT=2, DEF_LONG=5; expected values are hand-derived per edge.
module tb_traffic_interval_timer;

   localparam int CNT_W = 4;

   logic             clk = 1'b0;
   logic             rst;
   logic             st;
   logic [CNT_W-1:0] short_len;
   logic [CNT_W-1:0] long_len;
   logic             ts;
   logic             tl;
   logic             tick;
   logic [CNT_W-1:0] elapsed;

   int n_checks = 0;
   int n_errors = 0;

   traffic_interval_timer #(
      .CLK_DIV  (4),
      .CNT_W    (CNT_W),
      .DEF_SHORT(2),
      .DEF_LONG (5)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .ST       (st),
      .short_len(short_len),
      .long_len (long_len),
      .TS       (ts),
      .TL       (tl),
      .tick     (tick),
      .elapsed  (elapsed)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic check_all(input string tag, input int e_tick, input int e_el,
                            input int e_ts, input int e_tl);
      check($sformatf("%s.tick", tag), 32'(tick), 32'(e_tick));
      check($sformatf("%s.elapsed", tag), 32'(elapsed), 32'(e_el));
      check($sformatf("%s.TS", tag), 32'(ts), 32'(e_ts));
      check($sformatf("%s.TL", tag), 32'(tl), 32'(e_tl));
   endtask

   // Advance one clk edge and settle just past it.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // k edges after a restart (or reset release) with ST low: tick is high in
   // the cycle before every 4th edge, elapsed = k/4 saturating at 15.
   task automatic run_count(input string tag, input int n, input int s_len, input int l_len);
      int el;
      for (int k = 1; k <= n; k++) begin
         step();
         el = (k / 4 > 15) ? 15 : k / 4;
         check_all($sformatf("%s.k%0d", tag, k), (k % 4 == 3) ? 1 : 0, el,
                   (el >= s_len) ? 1 : 0, (el >= l_len) ? 1 : 0);
      end
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      rst       = 1'b1;
      st        = 1'b0;
      short_len = 4'd0;
      long_len  = 4'd0;

      // Reset held over several edges
      step();
      check_all("reset_a", 0, 0, 0, 0);
      step();
      check_all("reset_b", 0, 0, 0, 0);
      rst = 1'b0;

      // Defaults: TS after edge 8, TL after edge 20, no ST needed
      run_count("dflt", 24, 2, 5);

      // Restart with 3/6; later length changes while ST low must be ignored
      st = 1'b1; short_len = 4'd3; long_len = 4'd6;
      step();
      st = 1'b0; short_len = 4'd1; long_len = 4'd1;
      check_all("rstrt.t0", 0, 0, 0, 0);
      run_count("rstrt", 24, 3, 6);

      // ST held high 40 cycles pins the timer at zero
      st = 1'b1; short_len = 4'd3; long_len = 4'd6;
      for (int i = 1; i <= 40; i++) begin
         step();
         check_all($sformatf("hold.i%0d", i), 0, 0, 0, 0);
      end
      st = 1'b0; short_len = 4'd0; long_len = 4'd0;
      run_count("rel", 12, 3, 6);

      // Bring presc to the tick-condition value, then restart on that edge
      step();
      step();
      step();
      check_all("pre_coin", 1, 3, 1, 0);
      st = 1'b1; short_len = 4'd0; long_len = 4'd1;
      step();
      st = 1'b0; short_len = 4'd9; long_len = 4'd9;
      check_all("coin.t0", 0, 0, 1, 0);
      step();
      step();
      step();
      check_all("coin.t3", 1, 0, 1, 0);
      step();
      check_all("coin.t4", 0, 1, 1, 1);

      // Saturation: 100 more edges with ST low (k=4..104 since restart)
      for (int i = 0; i < 56; i++) step();
      check_all("sat.k60", 0, 15, 1, 1);
      for (int i = 0; i < 44; i++) step();
      check_all("sat.k104", 0, 15, 1, 1);

      // Mid-count asynchronous reset reverts everything including lengths
      st = 1'b1; short_len = 4'd3; long_len = 4'd6;
      step();
      st = 1'b0;
      for (int i = 0; i < 10; i++) step();
      check_all("mid.pre", 0, 2, 0, 0);
      #2;
      rst = 1'b1;
      #1;
      check_all("mid.async", 0, 0, 0, 0);
      step();
      check_all("mid.held", 0, 0, 0, 0);
      rst = 1'b0;
      run_count("dflt2", 24, 2, 5);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
